// File: rtl/rename_map_table_pkg.sv
// rename_pkg: shared sizes, index types and ring helper for the integer
// register alias table (RAT).
//   RENAME_WIDTH  lanes renamed per cycle
//   NUM_ARCH      architectural int registers (x0 is never renamed)
//   NUM_PHYS      physical int registers (>= NUM_ARCH)
//   NUM_CP        checkpoint slots (power of 2)
package rename_pkg;

  localparam int RENAME_WIDTH = 2;
  localparam int NUM_ARCH     = 32;
  localparam int NUM_PHYS     = 64;
  localparam int NUM_CP       = 4;

  localparam int ARCH_W = $clog2(NUM_ARCH);
  localparam int PHYS_W = $clog2(NUM_PHYS);
  localparam int CP_W   = $clog2(NUM_CP);
  localparam int LANE_W = (RENAME_WIDTH > 1) ? $clog2(RENAME_WIDTH) : 1;
  // One extra bit so a full ring and an empty ring have different counts.
  localparam int CNT_W  = CP_W + 1;

  typedef logic [ARCH_W-1:0] arch_idx_t;
  typedef logic [PHYS_W-1:0] phys_idx_t;
  typedef logic [CP_W-1:0]   cp_idx_t;
  typedef logic [LANE_W-1:0] lane_idx_t;
  typedef logic [CNT_W-1:0]  cp_cnt_t;

  // Full architectural-to-physical map, indexed by architectural register.
  typedef phys_idx_t [NUM_ARCH-1:0] rat_t;

  // Age of a slot relative to the oldest live slot; relies on NUM_CP being
  // a power of 2 so the subtraction wraps exactly like the ring pointers.
  function automatic cp_idx_t cp_age(input cp_idx_t slot, input cp_idx_t head);
    return slot - head;
  endfunction

endpackage

// File: rtl/rename_map_table_if.sv
// rename_map_table_if: rename group, checkpoint and branch-resolve signals.
//   master : frontend side (drives the group, resolve events)
//   slave  : the RAT (returns renamed tags, ready, checkpoint slot, full)
interface rename_map_table_if;
  import rename_pkg::*;

  logic                          rename_valid;
  logic                          rename_ready;
  logic      [RENAME_WIDTH-1:0]  rd_valid;
  arch_idx_t [RENAME_WIDTH-1:0]  rs1;
  arch_idx_t [RENAME_WIDTH-1:0]  rs2;
  arch_idx_t [RENAME_WIDTH-1:0]  rd;
  phys_idx_t [RENAME_WIDTH-1:0]  alloc_prd;
  phys_idx_t [RENAME_WIDTH-1:0]  prs1;
  phys_idx_t [RENAME_WIDTH-1:0]  prs2;
  phys_idx_t [RENAME_WIDTH-1:0]  prd;
  phys_idx_t [RENAME_WIDTH-1:0]  prev_prd;
  logic      [RENAME_WIDTH-1:0]  prev_valid;
  logic                          cp_req;
  lane_idx_t                     cp_lane;
  cp_idx_t                       cp_idx;
  logic                          resolve_valid;
  cp_idx_t                       resolve_idx;
  logic                          resolve_mispredict;
  logic                          cp_full;

  modport master (
    output rename_valid, rd_valid, rs1, rs2, rd, alloc_prd,
           cp_req, cp_lane, resolve_valid, resolve_idx, resolve_mispredict,
    input  rename_ready, prs1, prs2, prd, prev_prd, prev_valid, cp_idx, cp_full
  );

  modport slave (
    input  rename_valid, rd_valid, rs1, rs2, rd, alloc_prd,
           cp_req, cp_lane, resolve_valid, resolve_idx, resolve_mispredict,
    output rename_ready, prs1, prs2, prd, prev_prd, prev_valid, cp_idx, cp_full
  );

endinterface

// File: rtl/rename_map_table_cp_ring.sv
// rat_cp_ring: age-ordered ring of branch checkpoints for the RAT.
//   clock, reset        rising-edge clock, async active-high reset
//   alloc_en, alloc_map take a snapshot into the tail slot
//   resolve_*           branch resolution (release or restore/squash)
//   cp_idx              slot the next snapshot will use (tail)
//   cp_full             every slot live
//   restore_en/map      mispredict on a live slot and that slot's snapshot
module rat_cp_ring
  import rename_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    alloc_en,
  input  rat_t    alloc_map,
  input  logic    resolve_valid,
  input  cp_idx_t resolve_idx,
  input  logic    resolve_mispredict,
  output cp_idx_t cp_idx,
  output logic    cp_full,
  output logic    restore_en,
  output rat_t    restore_map
);

  rat_t              slots [NUM_CP];
  logic [NUM_CP-1:0] live_q;
  logic [NUM_CP-1:0] done_q;
  cp_idx_t           head_q;
  cp_idx_t           tail_q;
  cp_cnt_t           count_q;
  logic              release_en;
  logic              correct_en;
  cp_idx_t           squash_age;

  assign restore_en  = resolve_valid & resolve_mispredict & live_q[resolve_idx];
  assign correct_en  = resolve_valid & ~resolve_mispredict & live_q[resolve_idx];
  assign restore_map = slots[resolve_idx];
  assign cp_idx      = tail_q;
  assign cp_full     = (count_q == cp_cnt_t'(NUM_CP));
  assign squash_age  = cp_age(resolve_idx, head_q);

  // Only the oldest slot may retire, and only once its resolution has been
  // registered; a squash holds retirement off for that cycle.
  assign release_en  = live_q[head_q] & done_q[head_q] & ~restore_en;

  // Snapshot storage carries no reset: a slot is only read while live.
  always_ff @(posedge clock) begin
    if (alloc_en) slots[tail_q] <= alloc_map;
  end

  // A mispredict frees its own slot and everything younger, so the tail
  // rewinds onto the mispredicted slot and the ring stays contiguous.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      live_q  <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (restore_en) begin
      for (int j = 0; j < NUM_CP; j++) begin
        if (cp_age(cp_idx_t'(j), head_q) >= squash_age) begin
          live_q[j] <= 1'b0;
          done_q[j] <= 1'b0;
        end
      end
      tail_q  <= resolve_idx;
      count_q <= cp_cnt_t'(squash_age);
    end else begin
      if (correct_en) done_q[resolve_idx] <= 1'b1;
      if (release_en) begin
        live_q[head_q] <= 1'b0;
        done_q[head_q] <= 1'b0;
        head_q         <= head_q + 1'b1;
      end
      if (alloc_en) begin
        live_q[tail_q] <= 1'b1;
        done_q[tail_q] <= 1'b0;
        tail_q         <= tail_q + 1'b1;
      end
      count_q <= count_q + cp_cnt_t'(alloc_en) - cp_cnt_t'(release_en);
    end
  end

endmodule

// File: rtl/rename_map_table.sv
// rename_map_table: integer register alias table for the rename stage.
//   clock, reset  rising-edge clock, async active-high reset
//   rif (slave)   rename group in, renamed tags out, checkpoint allocate,
//                 branch resolve, ready and cp_full
// Lookups are combinational; the map commits on a fired group, or is
// overwritten from a checkpoint on a mispredict.
module rename_map_table
  import rename_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  rename_map_table_if.slave rif
);

  rat_t                         map_q;
  rat_t                         chain [RENAME_WIDTH+1];
  rat_t                         snap;
  rat_t                         restore_map;
  logic                         restore_en;
  logic                         cp_full;
  logic                         ready;
  logic                         fire;
  phys_idx_t [RENAME_WIDTH-1:0] prs1_c;
  phys_idx_t [RENAME_WIDTH-1:0] prs2_c;
  phys_idx_t [RENAME_WIDTH-1:0] prd_c;
  phys_idx_t [RENAME_WIDTH-1:0] prev_prd_c;
  logic      [RENAME_WIDTH-1:0] prev_valid_c;

  // chain[k] is the map as seen by lane k: the committed map plus the writes
  // of lanes 0..k-1. This gives RAW bypass for sources and the WAW chain for
  // prev_prd. The checkpoint snapshot is taken just after the branch lane.
  always_comb begin
    chain[0]     = map_q;
    snap         = map_q;
    prs1_c       = '0;
    prs2_c       = '0;
    prd_c        = '0;
    prev_prd_c   = '0;
    prev_valid_c = '0;
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      chain[k+1] = chain[k];
      if (rif.rs1[k] != '0) prs1_c[k] = chain[k][rif.rs1[k]];
      if (rif.rs2[k] != '0) prs2_c[k] = chain[k][rif.rs2[k]];
      if (rif.rd_valid[k] && (rif.rd[k] != '0)) begin
        prd_c[k]              = rif.alloc_prd[k];
        prev_prd_c[k]         = chain[k][rif.rd[k]];
        prev_valid_c[k]       = 1'b1;
        chain[k+1][rif.rd[k]] = rif.alloc_prd[k];
      end
      if (lane_idx_t'(k) == rif.cp_lane) snap = chain[k+1];
    end
  end

  // Stall while a restore is in flight, or when a branch needs a slot and
  // none is free.
  assign ready = ~restore_en & ~(rif.cp_req & cp_full);
  assign fire  = rif.rename_valid & ready;

  assign rif.rename_ready = ready;
  assign rif.cp_full      = cp_full;
  assign rif.prs1         = prs1_c;
  assign rif.prs2         = prs2_c;
  assign rif.prd          = prd_c;
  assign rif.prev_prd     = prev_prd_c;
  assign rif.prev_valid   = prev_valid_c;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ARCH; i++) map_q[i] <= phys_idx_t'(i);
    end else if (restore_en) begin
      map_q <= restore_map;
    end else if (fire) begin
      map_q <= chain[RENAME_WIDTH];
    end
  end

  rat_cp_ring u_cp_ring (
    .clock              (clock),
    .reset              (reset),
    .alloc_en           (fire & rif.cp_req),
    .alloc_map          (snap),
    .resolve_valid      (rif.resolve_valid),
    .resolve_idx        (rif.resolve_idx),
    .resolve_mispredict (rif.resolve_mispredict),
    .cp_idx             (rif.cp_idx),
    .cp_full            (cp_full),
    .restore_en         (restore_en),
    .restore_map        (restore_map)
  );

endmodule

// File: tb/tb_rename_map_table.sv
// tb_rename_map_table: directed scenarios plus randomized traffic against a
// queue-based reference model of the alias table and checkpoint ring.
module tb_rename_map_table;
  import rename_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  rename_map_table_if bus ();

  rename_map_table dut (
    .clock (clock),
    .reset (reset),
    .rif   (bus)
  );

  always #5 clock = ~clock;

  // Reference model: plain map array, live checkpoints kept oldest-first in a
  // queue of slot numbers, snapshots stored per slot.
  int m_map [NUM_ARCH];
  int cp_snap [NUM_CP][NUM_ARCH];
  bit done_m [NUM_CP];
  int live_list [$];
  int next_slot;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NUM_ARCH; i++) m_map[i] = i;
    for (int s = 0; s < NUM_CP; s++) done_m[s] = 1'b0;
    live_list.delete();
    next_slot = 0;
  endtask

  task automatic setIdle();
    bus.rename_valid       = 1'b0;
    bus.rd_valid           = '0;
    bus.rs1                = '0;
    bus.rs2                = '0;
    bus.rd                 = '0;
    bus.alloc_prd          = '0;
    bus.cp_req             = 1'b0;
    bus.cp_lane            = '0;
    bus.resolve_valid      = 1'b0;
    bus.resolve_idx        = '0;
    bus.resolve_mispredict = 1'b0;
  endtask

  task automatic applyStimulus();
    bus.rename_valid = ($urandom_range(0, 9) < 8);
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      bus.rd_valid[k]  = ($urandom_range(0, 3) != 0);
      bus.rd[k]        = arch_idx_t'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31)
                                                                  : $urandom_range(0, 5));
      bus.rs1[k]       = arch_idx_t'($urandom_range(0, 7));
      bus.rs2[k]       = arch_idx_t'($urandom_range(0, 31));
      bus.alloc_prd[k] = phys_idx_t'($urandom_range(1, NUM_PHYS - 1));
    end
    bus.cp_req        = ($urandom_range(0, 9) < 3);
    bus.cp_lane       = lane_idx_t'($urandom_range(0, RENAME_WIDTH - 1));
    bus.resolve_valid = ($urandom_range(0, 9) < 4);
    if (live_list.size() > 0 && $urandom_range(0, 3) != 0)
      bus.resolve_idx = cp_idx_t'(live_list[$urandom_range(0, live_list.size() - 1)]);
    else
      bus.resolve_idx = cp_idx_t'($urandom_range(0, NUM_CP - 1));
    bus.resolve_mispredict = ($urandom_range(0, 9) < 2);
  endtask

  // Compare all outputs against the model at the falling edge, advance the
  // model by one clock, and return just after the rising edge.
  task automatic runCycle();
    int tmp_map [NUM_ARCH];
    int snap [NUM_ARCH];
    int e_prs1, e_prs2, e_prd, e_prev, e_pv;
    int pos, ridx;
    bit mis_live, e_full, e_ready, e_fire, rel;
    @(negedge clock);
    for (int i = 0; i < NUM_ARCH; i++) begin
      tmp_map[i] = m_map[i];
      snap[i]    = m_map[i];
    end
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      e_prs1 = (bus.rs1[k] == 0) ? 0 : tmp_map[bus.rs1[k]];
      e_prs2 = (bus.rs2[k] == 0) ? 0 : tmp_map[bus.rs2[k]];
      if (bus.rd_valid[k] && bus.rd[k] != 0) begin
        e_prd  = bus.alloc_prd[k];
        e_prev = tmp_map[bus.rd[k]];
        e_pv   = 1;
        tmp_map[bus.rd[k]] = bus.alloc_prd[k];
      end else begin
        e_prd  = 0;
        e_prev = 0;
        e_pv   = 0;
      end
      if (k == int'(bus.cp_lane))
        for (int i = 0; i < NUM_ARCH; i++) snap[i] = tmp_map[i];
      checkOutput($sformatf("prs1[%0d]", k), bus.prs1[k], e_prs1);
      checkOutput($sformatf("prs2[%0d]", k), bus.prs2[k], e_prs2);
      checkOutput($sformatf("prd[%0d]", k), bus.prd[k], e_prd);
      checkOutput($sformatf("prev_valid[%0d]", k), bus.prev_valid[k], e_pv);
      if (e_pv != 0) checkOutput($sformatf("prev_prd[%0d]", k), bus.prev_prd[k], e_prev);
    end
    ridx = bus.resolve_idx;
    pos  = -1;
    for (int q = 0; q < live_list.size(); q++) if (live_list[q] == ridx) pos = q;
    mis_live = bus.resolve_valid && bus.resolve_mispredict && (pos >= 0);
    e_full   = (live_list.size() == NUM_CP);
    e_ready  = !mis_live && !(bus.cp_req && e_full);
    e_fire   = bus.rename_valid && e_ready;
    checkOutput("rename_ready", bus.rename_ready, e_ready);
    checkOutput("cp_full", bus.cp_full, e_full);
    if (e_fire && bus.cp_req) checkOutput("cp_idx", bus.cp_idx, next_slot);

    if (mis_live) begin
      for (int i = 0; i < NUM_ARCH; i++) m_map[i] = cp_snap[ridx][i];
      while (live_list.size() > pos) void'(live_list.pop_back());
      next_slot = ridx;
    end else begin
      rel = (live_list.size() > 0) && done_m[live_list[0]];
      if (bus.resolve_valid && !bus.resolve_mispredict && pos >= 0) done_m[ridx] = 1'b1;
      if (rel) void'(live_list.pop_front());
      if (e_fire) for (int i = 0; i < NUM_ARCH; i++) m_map[i] = tmp_map[i];
      if (e_fire && bus.cp_req) begin
        for (int i = 0; i < NUM_ARCH; i++) cp_snap[next_slot][i] = snap[i];
        done_m[next_slot] = 1'b0;
        live_list.push_back(next_slot);
        next_slot = (next_slot + 1) % NUM_CP;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    setIdle();
    modelReset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic fillCheckpoint();
    setIdle();
    bus.rename_valid = 1'b1;
    bus.cp_req       = 1'b1;
    runCycle();
  endtask

  initial begin
    setIdle();
    doReset();

    // Basic lookup after reset.
    $display("[TB] directed: lookup after reset");
    bus.rename_valid = 1'b1;
    bus.rs1[0] = 5;
    #2;
    checkOutput("t1_prs1", bus.prs1[0], 5);
    checkOutput("t1_prs2", bus.prs2[0], 0);
    checkOutput("t1_cp_full", bus.cp_full, 0);
    checkOutput("t1_ready", bus.rename_ready, 1);
    runCycle();

    // Intra-group RAW/WAW on r3.
    $display("[TB] directed: intra-group bypass");
    setIdle();
    bus.rename_valid = 1'b1;
    bus.rd_valid     = 2'b11;
    bus.rd[0] = 3;  bus.alloc_prd[0] = 40;
    bus.rs1[1] = 3; bus.rd[1] = 3; bus.alloc_prd[1] = 41;
    #2;
    checkOutput("t2_prs1_l1", bus.prs1[1], 40);
    checkOutput("t2_prev_l1", bus.prev_prd[1], 40);
    checkOutput("t2_prev_l0", bus.prev_prd[0], 3);
    runCycle();
    setIdle();
    bus.rs1[0] = 3;
    #2;
    checkOutput("t2_next_prs1", bus.prs1[0], 41);
    runCycle();

    // x0 as destination is never written.
    $display("[TB] directed: x0 destination");
    setIdle();
    bus.rename_valid = 1'b1;
    bus.rd_valid[0]  = 1'b1;
    bus.alloc_prd[0] = 9;
    #2;
    checkOutput("t3_prd", bus.prd[0], 0);
    checkOutput("t3_prev_valid", bus.prev_valid[0], 0);
    runCycle();

    // Checkpoint after lane 0, then mispredict.
    $display("[TB] directed: checkpoint and mispredict");
    setIdle();
    bus.rename_valid = 1'b1;
    bus.cp_req       = 1'b1;
    bus.rd_valid     = 2'b11;
    bus.rd[0] = 7; bus.alloc_prd[0] = 50;
    bus.rd[1] = 8; bus.alloc_prd[1] = 51;
    #2;
    checkOutput("t4_cp_idx", bus.cp_idx, 0);
    runCycle();
    setIdle();
    bus.rename_valid       = 1'b1;
    bus.resolve_valid      = 1'b1;
    bus.resolve_mispredict = 1'b1;
    #2;
    checkOutput("t4_ready_low", bus.rename_ready, 0);
    runCycle();
    setIdle();
    bus.rs1[0] = 7; bus.rs2[0] = 8;
    #2;
    checkOutput("t4_map7", bus.prs1[0], 50);
    checkOutput("t4_map8", bus.prs2[0], 8);
    runCycle();

    // Fill the ring, out-of-order resolve, in-order release.
    $display("[TB] directed: ring full and release");
    repeat (NUM_CP) fillCheckpoint();
    setIdle();
    bus.rename_valid = 1'b1;
    bus.cp_req       = 1'b1;
    #2;
    checkOutput("t5_full", bus.cp_full, 1);
    checkOutput("t5_stall", bus.rename_ready, 0);
    runCycle();
    setIdle();
    bus.resolve_valid = 1'b1;
    bus.resolve_idx   = 1;
    runCycle();
    setIdle();
    #2;
    checkOutput("t5_full_after_idx1", bus.cp_full, 1);
    runCycle();
    setIdle();
    bus.resolve_valid = 1'b1;
    bus.resolve_idx   = 0;
    runCycle();
    setIdle();
    #2;
    checkOutput("t5_full_before_release", bus.cp_full, 1);
    runCycle();
    setIdle();
    #2;
    checkOutput("t5_full_after_release", bus.cp_full, 0);
    runCycle();
    runCycle();

    // Async reset in the middle of a firing group with 3 live slots.
    $display("[TB] directed: reset mid-group");
    doReset();
    repeat (3) fillCheckpoint();
    setIdle();
    bus.rename_valid = 1'b1;
    bus.cp_req       = 1'b1;
    bus.rd_valid[0]  = 1'b1;
    bus.rd[0] = 7; bus.alloc_prd[0] = 55;
    #2;
    reset = 1'b1;
    setIdle();
    modelReset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    bus.rs1[0] = 7;
    #2;
    checkOutput("t6_map7", bus.prs1[0], 7);
    checkOutput("t6_cp_full", bus.cp_full, 0);
    checkOutput("t6_cp_idx", bus.cp_idx, 0);
    runCycle();

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      applyStimulus();
      runCycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
